// File: rtl/wave_period_extract.sv
// Peak-to-peak period extractor: finds hysteretic zero-slope crossings in a derivative
// stream, buffers the samples between adjacent peaks and replays one period as a framed burst.
module wave_period_extract #(
    parameter int DATA_W     = 8,
    parameter int HYST       = 8,
    parameter int MAX_PERIOD = 64,
    parameter int BUF_AW     = 7
) (
    input  logic              clk_50M,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_first,
    output logic              out_last,
    output logic [6:0]        out_len,
    output logic [9:0]        period_cnt,
    output logic [7:0]        drop_cnt
);

    localparam int                MID     = 1 << (DATA_W - 1);
    localparam logic [DATA_W-1:0] ARM_TH  = DATA_W'(MID - HYST);
    localparam logic [DATA_W-1:0] PEAK_TH = DATA_W'(MID + HYST);
    localparam logic [BUF_AW-1:0] LEN_MIN = BUF_AW'(2);
    localparam logic [BUF_AW-1:0] LEN_MAX = BUF_AW'(MAX_PERIOD);
    localparam logic [BUF_AW-1:0] LEN_TO  = BUF_AW'(MAX_PERIOD + 1);

    typedef enum logic {CAP_HUNT, CAP_TRACK} cap_state_t;
    typedef enum logic [1:0] {DR_IDLE, DR_DRAIN, DR_LAST} dr_state_t;

    logic [DATA_W-1:0] r_buf [0:(2**BUF_AW)-1];

    cap_state_t        r_cap;
    dr_state_t         r_dr;
    logic [BUF_AW-1:0] r_wr_ptr;
    logic [BUF_AW-1:0] r_start_ptr;
    logic [BUF_AW-1:0] r_rd_ptr;
    logic [BUF_AW-1:0] r_remaining;
    logic              r_armed;
    logic              r_first_pend;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_first;
    logic              r_out_last;
    logic [6:0]        r_out_len;
    logic [9:0]        r_period_cnt;
    logic [7:0]        r_drop_cnt;

    logic              w_peak;
    logic [BUF_AW-1:0] w_len;
    logic              w_len_ok;
    logic              w_launch;
    logic              w_timeout;
    logic              w_drop;

    // The peak sample itself is not yet in the buffer, so w_len counts the previous period only.
    assign w_peak    = in_valid && r_armed && (in_data >= PEAK_TH);
    assign w_len     = r_wr_ptr - r_start_ptr;
    assign w_len_ok  = (w_len >= LEN_MIN) && (w_len <= LEN_MAX);
    assign w_launch  = w_peak && (r_cap == CAP_TRACK) && w_len_ok && (r_dr == DR_IDLE);
    assign w_timeout = in_valid && !w_peak && (r_cap == CAP_TRACK) && (w_len == LEN_TO);
    assign w_drop    = (w_peak && (r_cap == CAP_TRACK) && !w_launch) || w_timeout;

    always_ff @(posedge clk_50M) begin
        if (in_valid) begin
            r_buf[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            r_cap       <= CAP_HUNT;
            r_wr_ptr    <= '0;
            r_start_ptr <= '0;
            r_armed     <= 1'b0;
            r_drop_cnt  <= '0;
        end else if (in_valid) begin
            r_wr_ptr <= r_wr_ptr + BUF_AW'(1);
            if (in_data < ARM_TH) begin
                r_armed <= 1'b1;
            end else if (w_peak) begin
                r_armed <= 1'b0;
            end
            case (r_cap)
                CAP_HUNT: begin
                    if (w_peak) begin
                        r_start_ptr <= r_wr_ptr;
                        r_cap       <= CAP_TRACK;
                    end
                end
                CAP_TRACK: begin
                    if (w_peak) begin
                        r_start_ptr <= r_wr_ptr;
                    end else if (w_timeout) begin
                        r_cap <= CAP_HUNT;
                    end
                end
                default: r_cap <= CAP_HUNT;
            endcase
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    // DR_LAST covers the out_last beat so a coincident peak still sees the replay as busy.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            r_dr         <= DR_IDLE;
            r_rd_ptr     <= '0;
            r_remaining  <= '0;
            r_first_pend <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_first  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_len    <= '0;
            r_period_cnt <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
            case (r_dr)
                DR_IDLE: begin
                    if (w_launch) begin
                        r_dr         <= DR_DRAIN;
                        r_rd_ptr     <= r_start_ptr;
                        r_remaining  <= w_len;
                        r_out_len    <= 7'(w_len);
                        r_first_pend <= 1'b1;
                    end
                end
                DR_DRAIN: begin
                    r_out_valid  <= 1'b1;
                    r_out_data   <= r_buf[r_rd_ptr];
                    r_out_first  <= r_first_pend;
                    r_first_pend <= 1'b0;
                    r_rd_ptr     <= r_rd_ptr + BUF_AW'(1);
                    r_remaining  <= r_remaining - BUF_AW'(1);
                    if (r_remaining == BUF_AW'(1)) begin
                        r_out_last   <= 1'b1;
                        r_period_cnt <= r_period_cnt + 10'd1;
                        r_dr         <= DR_LAST;
                    end
                end
                DR_LAST: r_dr <= DR_IDLE;
                default: r_dr <= DR_IDLE;
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_first  = r_out_first;
    assign out_last   = r_out_last;
    assign out_len    = r_out_len;
    assign period_cnt = r_period_cnt;
    assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_wave_period_extract.sv
// Bench for wave_period_extract: directed tables and sequences plus random periods
// scored against a sample-index model of peaks, periods and replay timing.
module tb_wave_period_extract;

    localparam int DATA_W     = 8;
    localparam int HYST       = 8;
    localparam int MAX_PERIOD = 64;
    localparam int BUF_AW     = 7;

    logic              clk_50M = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_first;
    logic              out_last;
    logic [6:0]        out_len;
    logic [9:0]        period_cnt;
    logic [7:0]        drop_cnt;

    wave_period_extract #(
        .DATA_W(DATA_W), .HYST(HYST), .MAX_PERIOD(MAX_PERIOD), .BUF_AW(BUF_AW)
    ) dut (
        .clk_50M(clk_50M), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .out_first(out_first),
        .out_last(out_last), .out_len(out_len), .period_cnt(period_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk_50M = ~clk_50M;

    longint cyc = 0;
    always @(posedge clk_50M) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int n_bursts = 0;

    typedef struct {
        logic [7:0] d;
        bit         first;
        bit         last;
        int         len;
        longint     due;
    } beat_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         exp_bursts;
        int         exp_len;
    } vec_t;

    beat_t      expq[$];
    logic [7:0] hist[$];
    bit         m_armed;
    bit         m_track;
    int         m_start;
    longint     m_busy_until;
    int         m_drop;
    int         m_period;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        expq.delete();
        hist.delete();
        m_armed      = 1'b0;
        m_track      = 1'b0;
        m_start      = 0;
        m_busy_until = -1;
        m_drop       = 0;
        m_period     = 0;
    endfunction

    // Sample-index view: a period is hist[start .. n-1], replay beat k is due at c+2+k.
    function automatic void model_accept(input logic [7:0] d, input longint c);
        int    n;
        int    len;
        bit    pk;
        beat_t b;
        n  = hist.size();
        pk = m_armed && (int'(d) >= 128 + HYST);
        if (int'(d) < 128 - HYST) m_armed = 1'b1;
        else if (pk) m_armed = 1'b0;
        if (m_track) begin
            len = n - m_start;
            if (pk) begin
                if (len >= 2 && len <= MAX_PERIOD && c > m_busy_until) begin
                    for (int k = 0; k < len; k++) begin
                        b.d     = hist[m_start + k];
                        b.first = (k == 0);
                        b.last  = (k == len - 1);
                        b.len   = len;
                        b.due   = c + 2 + k;
                        expq.push_back(b);
                    end
                    m_busy_until = c + 1 + len;
                end else if (m_drop < 255) begin
                    m_drop++;
                end
                m_start = n;
            end else if (len == MAX_PERIOD + 1) begin
                if (m_drop < 255) m_drop++;
                m_track = 1'b0;
            end
        end else if (pk) begin
            m_track = 1'b1;
            m_start = n;
        end
        hist.push_back(d);
    endfunction

    always @(negedge clk_50M) begin
        beat_t b;
        if (!rst) begin
            while (expq.size() > 0 && expq[0].due < cyc) begin
                b = expq.pop_front();
                chk("missing_beat", 64'(cyc), 64'(b.due));
            end
            if (out_valid) begin
                if (expq.size() == 0) begin
                    chk("unexpected_beat", {63'd0, out_valid}, 64'd0);
                end else begin
                    b = expq.pop_front();
                    chk("beat", {15'd0, out_data, out_first, out_last, out_len, cyc[31:0]},
                                {15'd0, b.d, b.first, b.last, 7'(b.len), b.due[31:0]});
                    if (b.last) begin
                        m_period++;
                        n_bursts++;
                        chk("period_cnt_at_last", 64'(period_cnt), 64'(10'(m_period)));
                    end
                end
            end
        end
    end

    task automatic step(input bit v, input logic [7:0] d);
        in_valid = v;
        in_data  = d;
        if (v) model_accept(d, cyc);
        @(posedge clk_50M);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00);
    endtask

    task automatic seq(input int n, input logic [7:0] v, input int gap);
        repeat (n) begin
            step(1'b1, v);
            repeat (gap) step(1'b0, 8'h00);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk_50M);
        #1;
        model_reset();
        chk("reset_outputs", {31'd0, out_valid, out_data, out_first, out_last, out_len, period_cnt, drop_cnt},
            64'd0);
        @(posedge clk_50M);
        #1;
        rst = 1'b0;
    endtask

    task automatic basic_pattern(input int gap);
        int b0;
        do_reset();
        b0 = n_bursts;
        seq(10, 8'd100, gap);
        seq(10, 8'd156, gap);
        idle(5);
        chk("first_peak_silent", 64'(n_bursts - b0), 64'd0);
        seq(10, 8'd100, gap);
        seq(10, 8'd156, gap);
        idle(60);
        chk("basic_bursts", 64'(n_bursts - b0), 64'd1);
        chk("basic_len", 64'(out_len), 64'd20);
        chk("basic_period_cnt", 64'(period_cnt), 64'd1);
        chk("basic_drop_cnt", 64'(drop_cnt), 64'd0);
    endtask

    vec_t       vt[8];
    int         b0;
    int         l1;
    int         l2;
    int         maxgap;
    logic [7:0] v;

    initial begin
        vt[0] = '{a: 8'd121, b: 8'd135, exp_bursts: 0, exp_len: 0};
        vt[1] = '{a: 8'd128, b: 8'd130, exp_bursts: 0, exp_len: 0};
        vt[2] = '{a: 8'd120, b: 8'd136, exp_bursts: 1, exp_len: 3};
        vt[3] = '{a: 8'd119, b: 8'd135, exp_bursts: 0, exp_len: 0};
        vt[4] = '{a: 8'd135, b: 8'd136, exp_bursts: 1, exp_len: 3};
        vt[5] = '{a: 8'd119, b: 8'd200, exp_bursts: 1, exp_len: 3};
        vt[6] = '{a: 8'd0,   b: 8'd255, exp_bursts: 1, exp_len: 3};
        vt[7] = '{a: 8'd127, b: 8'd134, exp_bursts: 0, exp_len: 0};

        basic_pattern(0);
        basic_pattern(3);

        // Hysteresis table: armed state entering each (a, b) pair.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            b0 = n_bursts;
            seq(1, 8'd100, 0);
            seq(1, 8'd156, 0);
            seq(1, 8'd100, 0);
            step(1'b1, vt[i].a);
            step(1'b1, vt[i].b);
            idle(10);
            chk("hyst_bursts", 64'(n_bursts - b0), 64'(vt[i].exp_bursts));
            chk("hyst_len", 64'(out_len), 64'(vt[i].exp_len));
        end

        do_reset();
        b0 = n_bursts;
        seq(1, 8'd100, 0);
        seq(1, 8'd156, 0);
        seq(1, 8'd100, 0);
        for (int k = 121; k <= 135; k++) step(1'b1, 8'(k));
        idle(10);
        chk("band_no_peak", 64'(n_bursts - b0), 64'd0);

        // Length limits and timeout.
        do_reset();
        b0 = n_bursts;
        seq(1, 8'd100, 0);
        seq(1, 8'd156, 0);
        seq(32, 8'd156, 0);
        seq(32, 8'd100, 0);
        seq(1, 8'd156, 0);
        idle(5);
        chk("len65_drop", 64'(drop_cnt), 64'd1);
        chk("len65_no_burst", 64'(n_bursts - b0), 64'd0);
        seq(31, 8'd156, 0);
        seq(32, 8'd100, 0);
        seq(1, 8'd156, 0);
        idle(80);
        chk("len64_burst", 64'(n_bursts - b0), 64'd1);
        chk("len64_len", 64'(out_len), 64'd64);
        seq(65, 8'd128, 0);
        idle(3);
        chk("timeout_drop", 64'(drop_cnt), 64'd2);
        seq(1, 8'd100, 0);
        seq(1, 8'd156, 0);
        idle(5);
        chk("hunt_after_timeout", {32'(drop_cnt), 32'(n_bursts - b0)}, {32'd2, 32'd1});
        seq(1, 8'd100, 0);
        seq(1, 8'd156, 0);
        idle(10);
        chk("len2_burst", {32'(out_len), 32'(n_bursts - b0)}, {32'd2, 32'd2});

        // Drain busy: 40-sample period then a 2-sample one at full rate.
        do_reset();
        b0 = n_bursts;
        seq(1, 8'd100, 0);
        seq(1, 8'd156, 0);
        seq(19, 8'd156, 0);
        seq(20, 8'd100, 0);
        seq(1, 8'd156, 0);
        seq(1, 8'd100, 0);
        seq(1, 8'd156, 0);
        idle(60);
        chk("busy_drop", 64'(drop_cnt), 64'd1);
        chk("busy_bursts", 64'(n_bursts - b0), 64'd1);
        chk("busy_len", 64'(out_len), 64'd40);
        chk("busy_period_cnt", 64'(period_cnt), 64'd1);

        // Reset in the middle of a replay.
        do_reset();
        b0 = n_bursts;
        seq(10, 8'd100, 0);
        seq(10, 8'd156, 0);
        seq(10, 8'd100, 0);
        seq(1, 8'd156, 0);
        idle(5);
        do_reset();
        seq(10, 8'd100, 0);
        seq(10, 8'd156, 0);
        idle(30);
        chk("post_reset_silent", 64'(n_bursts - b0), 64'd0);
        seq(10, 8'd100, 0);
        seq(1, 8'd156, 0);
        idle(30);
        chk("post_reset_burst", {32'(out_len), 32'(n_bursts - b0)}, {32'd20, 32'd1});

        // Random periods, first with sparse strobes, then at full rate.
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            maxgap = (pass == 0) ? 3 : 0;
            for (int r = 0; r < 60; r++) begin
                l1 = int'($urandom_range(1, 36));
                l2 = int'($urandom_range(1, 36));
                for (int k = 0; k < l1 + l2; k++) begin
                    if ($urandom_range(0, 9) == 0) v = 8'($urandom_range(121, 135));
                    else if (k < l1) v = 8'($urandom_range(0, 119));
                    else v = 8'($urandom_range(136, 255));
                    step(1'b1, v);
                    if (maxgap > 0 && $urandom_range(0, 3) == 0) idle(int'($urandom_range(1, maxgap)));
                end
            end
            idle(100);
            chk("random_queue_empty", 64'(expq.size()), 64'd0);
            chk("random_drop_cnt", 64'(drop_cnt), 64'(8'(m_drop)));
            chk("random_period_cnt", 64'(period_cnt), 64'(10'(m_period)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
